// File: rtl/motion_zone_detector.sv
// Frame-difference motion detector: per-zone changed-pixel counts with frame-level hysteresis flags.
// Define MOTION_BBOX_EN to add bounding-box outputs for the changed pixels of each closed frame.
module motion_zone_detector #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int PIX_W        = 8,
  parameter int ZONES        = 4,
  parameter int PIX_THRESH   = 48,
  parameter int COUNT_THRESH = 256,
  parameter int HOLD_FRAMES  = 2,
  parameter int CNT_W        = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic                     pixel_valid,
  input  logic [9:0]               pixel_x,
  input  logic [9:0]               pixel_y,
  input  logic [3*PIX_W-1:0]       cur_rgb,
  input  logic [3*PIX_W-1:0]       prev_rgb,
  output logic                     frame_done,
  output logic [ZONES-1:0]         motion_zone,
  output logic                     motion_any,
  output logic [ZONES*CNT_W-1:0]   zone_count
`ifdef MOTION_BBOX_EN
  ,
  output logic [9:0]               bbox_xmin,
  output logic [9:0]               bbox_xmax,
  output logic [9:0]               bbox_ymin,
  output logic [9:0]               bbox_ymax,
  output logic                     bbox_valid
`endif
);

  localparam int ZONE_W = WIDTH / ZONES;
  localparam int ZI_W   = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int SUM_W  = PIX_W + 2;
  localparam int ST_W   = 4;

  localparam logic [9:0]       WIDTH_C    = 10'(WIDTH);
  localparam logic [9:0]       HEIGHT_C   = 10'(HEIGHT);
  localparam logic [SUM_W-1:0] PIX_TH_C   = SUM_W'(PIX_THRESH);
  localparam logic [CNT_W-1:0] CNT_TH_C   = CNT_W'(COUNT_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX_C  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ST_W-1:0]  HOLD_C     = ST_W'(HOLD_FRAMES);

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    logic [PIX_W-1:0] d;
    if (a >= b) d = a - b;
    else        d = b - a;
    return d;
  endfunction

  // Thresholds rise with k, so the last boundary passed names the strip.
  function automatic logic [ZI_W-1:0] zone_of(input logic [9:0] x);
    logic [ZI_W-1:0] z;
    z = {ZI_W{1'b0}};
    for (int k = 1; k < ZONES; k++) begin
      z = (x >= 10'(k * ZONE_W)) ? ZI_W'(k) : z;
    end
    return z;
  endfunction

  logic              accept_s;
  logic [SUM_W-1:0]  sum_s;

  logic              s1_valid_r;
  logic              s1_tag_r;
  logic [PIX_W-1:0]  s1_dr_r;
  logic [PIX_W-1:0]  s1_dg_r;
  logic [PIX_W-1:0]  s1_db_r;
  logic [ZI_W-1:0]   s1_zone_r;

  logic              s2_valid_r;
  logic              s2_tag_r;
  logic              s2_changed_r;
  logic [ZI_W-1:0]   s2_zone_r;

  logic              opened_r;
  logic [CNT_W-1:0]  acc_r         [ZONES];
  logic [ST_W-1:0]   streak_r      [ZONES];
  logic [ST_W-1:0]   streak_inc_s  [ZONES];
  logic [ST_W-1:0]   streak_next_s [ZONES];
  logic [ZONES-1:0]  raw_s;
  logic [ZONES-1:0]  flag_next_s;

  assign accept_s = pixel_valid && !frame_start &&
                    (pixel_x < WIDTH_C) && (pixel_y < HEIGHT_C);

  assign sum_s = {2'b00, s1_dr_r} + {2'b00, s1_dg_r} + {2'b00, s1_db_r};

  // Stage 1: per-channel absolute differences and strip index.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_tag_r   <= 1'b0;
      s1_dr_r    <= {PIX_W{1'b0}};
      s1_dg_r    <= {PIX_W{1'b0}};
      s1_db_r    <= {PIX_W{1'b0}};
      s1_zone_r  <= {ZI_W{1'b0}};
    end else begin
      s1_valid_r <= accept_s;
      s1_tag_r   <= frame_start;
      s1_dr_r    <= abs_diff(cur_rgb[3*PIX_W-1 -: PIX_W], prev_rgb[3*PIX_W-1 -: PIX_W]);
      s1_dg_r    <= abs_diff(cur_rgb[2*PIX_W-1 -: PIX_W], prev_rgb[2*PIX_W-1 -: PIX_W]);
      s1_db_r    <= abs_diff(cur_rgb[PIX_W-1:0], prev_rgb[PIX_W-1:0]);
      s1_zone_r  <= zone_of(pixel_x);
    end
  end

  // Stage 2: summed difference compared against the pixel threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r   <= 1'b0;
      s2_tag_r     <= 1'b0;
      s2_changed_r <= 1'b0;
      s2_zone_r    <= {ZI_W{1'b0}};
    end else begin
      s2_valid_r   <= s1_valid_r;
      s2_tag_r     <= s1_tag_r;
      s2_changed_r <= (sum_s > PIX_TH_C);
      s2_zone_r    <= s1_zone_r;
    end
  end

  // Next flag and streak per zone, evaluated against the frame being closed.
  always_comb begin
    for (int z = 0; z < ZONES; z++) begin
      raw_s[z]         = (acc_r[z] >= CNT_TH_C);
      streak_inc_s[z]  = streak_r[z] + 4'd1;
      flag_next_s[z]   = motion_zone[z];
      streak_next_s[z] = 4'd0;
      if (raw_s[z] != motion_zone[z]) begin
        if (streak_inc_s[z] == HOLD_C) begin
          flag_next_s[z]   = ~motion_zone[z];
          streak_next_s[z] = 4'd0;
        end else begin
          streak_next_s[z] = streak_inc_s[z];
        end
      end else begin
        streak_next_s[z] = 4'd0;
      end
    end
  end

  // Stage 3: zone accumulation; a frame tag publishes counts and flags and restarts counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      opened_r    <= 1'b0;
      frame_done  <= 1'b0;
      motion_zone <= {ZONES{1'b0}};
      motion_any  <= 1'b0;
      zone_count  <= {(ZONES*CNT_W){1'b0}};
      for (int z = 0; z < ZONES; z++) begin
        acc_r[z]    <= {CNT_W{1'b0}};
        streak_r[z] <= 4'd0;
      end
    end else if (s2_tag_r) begin
      opened_r   <= 1'b1;
      frame_done <= opened_r;
      for (int z = 0; z < ZONES; z++) begin
        acc_r[z] <= {CNT_W{1'b0}};
      end
      if (opened_r) begin
        motion_zone <= flag_next_s;
        motion_any  <= |flag_next_s;
        for (int z = 0; z < ZONES; z++) begin
          zone_count[z*CNT_W +: CNT_W] <= acc_r[z];
          streak_r[z]                  <= streak_next_s[z];
        end
      end
    end else begin
      frame_done <= 1'b0;
      if (s2_valid_r && s2_changed_r && (acc_r[s2_zone_r] != CNT_MAX_C)) begin
        acc_r[s2_zone_r] <= acc_r[s2_zone_r] + CNT_ONE_C;
      end
    end
  end

`ifdef MOTION_BBOX_EN
  logic [9:0] s1_x_r;
  logic [9:0] s1_y_r;
  logic [9:0] s2_x_r;
  logic [9:0] s2_y_r;
  logic [9:0] trk_xmin_r;
  logic [9:0] trk_xmax_r;
  logic [9:0] trk_ymin_r;
  logic [9:0] trk_ymax_r;
  logic       trk_any_r;

  // Pixel coordinates travel alongside the difference pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_x_r <= 10'd0;
      s1_y_r <= 10'd0;
      s2_x_r <= 10'd0;
      s2_y_r <= 10'd0;
    end else begin
      s1_x_r <= pixel_x;
      s1_y_r <= pixel_y;
      s2_x_r <= s1_x_r;
      s2_y_r <= s1_y_r;
    end
  end

  // Bounding-box trackers, published and re-armed on each frame close.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_xmin_r <= 10'h3FF;
      trk_xmax_r <= 10'd0;
      trk_ymin_r <= 10'h3FF;
      trk_ymax_r <= 10'd0;
      trk_any_r  <= 1'b0;
      bbox_xmin  <= 10'd0;
      bbox_xmax  <= 10'd0;
      bbox_ymin  <= 10'd0;
      bbox_ymax  <= 10'd0;
      bbox_valid <= 1'b0;
    end else if (s2_tag_r) begin
      trk_xmin_r <= 10'h3FF;
      trk_xmax_r <= 10'd0;
      trk_ymin_r <= 10'h3FF;
      trk_ymax_r <= 10'd0;
      trk_any_r  <= 1'b0;
      if (opened_r) begin
        bbox_valid <= trk_any_r;
        bbox_xmin  <= trk_any_r ? trk_xmin_r : 10'd0;
        bbox_xmax  <= trk_any_r ? trk_xmax_r : 10'd0;
        bbox_ymin  <= trk_any_r ? trk_ymin_r : 10'd0;
        bbox_ymax  <= trk_any_r ? trk_ymax_r : 10'd0;
      end
    end else if (s2_valid_r && s2_changed_r) begin
      trk_any_r <= 1'b1;
      if (s2_x_r < trk_xmin_r) trk_xmin_r <= s2_x_r;
      if (s2_x_r > trk_xmax_r) trk_xmax_r <= s2_x_r;
      if (s2_y_r < trk_ymin_r) trk_ymin_r <= s2_y_r;
      if (s2_y_r > trk_ymax_r) trk_ymax_r <= s2_y_r;
    end
  end
`endif

endmodule

// File: tb/tb_motion_zone_detector.sv
// Randomised and directed bench for motion_zone_detector against a frame-level reference model.
module tb_motion_zone_detector;

  localparam int W    = 16;
  localparam int H    = 4;
  localparam int Z    = 4;
  localparam int PT   = 48;
  localparam int CT   = 3;
  localparam int HF   = 2;
  localparam int CW   = 6;
  localparam int ZW   = W / Z;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [23:0] GREY = 24'h646464;
  localparam logic [23:0] CHG  = 24'hFF6464;

  logic            clk;
  logic            rst;
  logic            frame_start;
  logic            pixel_valid;
  logic [9:0]      pixel_x;
  logic [9:0]      pixel_y;
  logic [23:0]     cur_rgb;
  logic [23:0]     prev_rgb;
  logic            frame_done;
  logic [Z-1:0]    motion_zone;
  logic            motion_any;
  logic [Z*CW-1:0] zone_count;
`ifdef MOTION_BBOX_EN
  logic [9:0]      bbox_xmin;
  logic [9:0]      bbox_xmax;
  logic [9:0]      bbox_ymin;
  logic [9:0]      bbox_ymax;
  logic            bbox_valid;
`endif

  motion_zone_detector #(
    .WIDTH(W), .HEIGHT(H), .PIX_W(8), .ZONES(Z), .PIX_THRESH(PT),
    .COUNT_THRESH(CT), .HOLD_FRAMES(HF), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .cur_rgb(cur_rgb), .prev_rgb(prev_rgb),
    .frame_done(frame_done), .motion_zone(motion_zone), .motion_any(motion_any),
    .zone_count(zone_count)
`ifdef MOTION_BBOX_EN
    , .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax), .bbox_ymin(bbox_ymin),
    .bbox_ymax(bbox_ymax), .bbox_valid(bbox_valid)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: counts per frame, flags, streaks, bounding box.
  int  m_cnt    [Z];
  bit  m_flag   [Z];
  int  m_streak [Z];
  bit  m_open;
  int  m_xmin, m_xmax, m_ymin, m_ymax;
  bit  m_bany;

  // Scheduled output updates, indexed by cycle modulo 4 (outputs lag inputs by 3).
  int              r_kind [4];
  logic [Z*CW-1:0] r_cnt  [4];
  logic [Z-1:0]    r_flag [4];
  logic [40:0]     r_bbox [4];

  bit              chk_en = 1'b0;
  bit              e_done;
  logic [Z*CW-1:0] e_cnt;
  logic [Z-1:0]    e_flag;
  logic [40:0]     e_bbox;

  int              n_done = 0;
  int              done_cyc = 0;
  logic [Z*CW-1:0] last_cnt;
  logic [Z-1:0]    last_flag;
  logic            last_any;
  logic [40:0]     last_bbox;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit is_changed(input logic [23:0] c, input logic [23:0] p);
    int s;
    int a;
    int b;
    s = 0;
    for (int ch = 0; ch < 3; ch++) begin
      a = int'(c[ch*8 +: 8]);
      b = int'(p[ch*8 +: 8]);
      s += (a > b) ? a - b : b - a;
    end
    return s > PT;
  endfunction

  task automatic model_clear_frame();
    for (int z = 0; z < Z; z++) m_cnt[z] = 0;
    m_xmin = 1023; m_xmax = 0; m_ymin = 1023; m_ymax = 0; m_bany = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit fs, input bit pv, input int x, input int y,
                            input logic [23:0] c, input logic [23:0] p);
    int  s3;
    int  zi;
    bit  raw;
    s3 = (cyc + 3) % 4;
    r_kind[s3] = 0;
    if (r) begin
      r_kind[(cyc + 1) % 4] = 2;
      r_kind[(cyc + 2) % 4] = 0;
      m_open = 1'b0;
      for (int z = 0; z < Z; z++) begin
        m_flag[z] = 1'b0;
        m_streak[z] = 0;
      end
      model_clear_frame();
    end else if (fs) begin
      if (m_open) begin
        for (int z = 0; z < Z; z++) begin
          raw = (m_cnt[z] >= CT);
          if (raw != m_flag[z]) begin
            m_streak[z]++;
            if (m_streak[z] >= HF) begin
              m_flag[z] = !m_flag[z];
              m_streak[z] = 0;
            end
          end else begin
            m_streak[z] = 0;
          end
          r_cnt[s3][z*CW +: CW] = CW'(m_cnt[z]);
          r_flag[s3][z] = m_flag[z];
        end
        r_bbox[s3] = m_bany ? {1'b1, 10'(m_xmin), 10'(m_xmax), 10'(m_ymin), 10'(m_ymax)} : 41'd0;
        r_kind[s3] = 1;
      end
      m_open = 1'b1;
      model_clear_frame();
    end else if (pv && x < W && y < H && is_changed(c, p)) begin
      zi = x / ZW;
      if (m_cnt[zi] < CMAX) m_cnt[zi]++;
      m_bany = 1'b1;
      if (x < m_xmin) m_xmin = x;
      if (x > m_xmax) m_xmax = x;
      if (y < m_ymin) m_ymin = y;
      if (y > m_ymax) m_ymax = y;
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then compare outputs mid-cycle.
  task automatic step(input bit r, input bit fs, input bit pv, input int x, input int y,
                      input logic [23:0] c, input logic [23:0] p);
    @(posedge clk);
    #1;
    cyc++;
    rst = r; frame_start = fs; pixel_valid = pv;
    pixel_x = 10'(x); pixel_y = 10'(y); cur_rgb = c; prev_rgb = p;
    model_step(r, fs, pv, x, y, c, p);
    @(negedge clk);
    case (r_kind[cyc % 4])
      1: begin
        e_done = 1'b1; e_cnt = r_cnt[cyc % 4]; e_flag = r_flag[cyc % 4]; e_bbox = r_bbox[cyc % 4];
      end
      2: begin
        e_done = 1'b0; e_cnt = '0; e_flag = '0; e_bbox = '0; chk_en = 1'b1;
      end
      default: e_done = 1'b0;
    endcase
    if (chk_en) begin
      check("frame_done", frame_done, e_done);
      check("zone_count", zone_count, e_cnt);
      check("motion_zone", motion_zone, e_flag);
      check("motion_any", motion_any, |e_flag);
`ifdef MOTION_BBOX_EN
      check("bbox", {bbox_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}, e_bbox);
`endif
    end
    if (frame_done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
      last_cnt = zone_count;
      last_flag = motion_zone;
      last_any = motion_any;
`ifdef MOTION_BBOX_EN
      last_bbox = {bbox_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax};
`endif
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, GREY, GREY);
  endtask

  task automatic pix(input int x, input int y, input bit chg);
    step(1'b0, 1'b0, 1'b1, x, y, chg ? CHG : GREY, GREY);
  endtask

  task automatic reset_and_open();
    step(1'b1, 1'b0, 1'b0, 0, 0, GREY, GREY);
    step(1'b0, 1'b1, 1'b0, 0, 0, GREY, GREY);
  endtask

  // Close the frame (optionally with a colliding pixel) and wait, bounded, for frame_done.
  task automatic close_frame(input bit with_pix);
    int fs_cyc;
    int n0;
    n0 = n_done;
    step(1'b0, 1'b1, with_pix, 0, 0, CHG, GREY);
    fs_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      if (n_done == n0) idle(1);
    end
    check("done_count", n_done - n0, 1);
    check("done_latency", done_cyc - fs_cyc, 3);
  endtask

  bit exp3 [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int n_mark;
    logic [23:0] c;
    logic [23:0] p;
    rst = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0;
    pixel_x = 10'd0; pixel_y = 10'd0; cur_rgb = GREY; prev_rgb = GREY;

    // Static frame: opening pulse gives nothing, close gives zero counts.
    step(1'b1, 1'b0, 1'b0, 0, 0, GREY, GREY);
    n_mark = n_done;
    step(1'b0, 1'b1, 1'b0, 0, 0, GREY, GREY);
    for (int i = 0; i < 64; i++) pix(i % W, i / W, 1'b0);
    check("open_no_done", n_done - n_mark, 0);
    close_frame(1'b0);
    check("static_counts", last_cnt, 24'h000000);
    check("static_flags", last_flag, 4'h0);

    // Threshold edge: sum of 48 is not changed, 49 is.
    reset_and_open();
    for (int x = 4; x < 8; x++) begin
      if (x < 6) step(1'b0, 1'b0, 1'b1, x, 0, 24'h747474, GREY);
      else       step(1'b0, 1'b0, 1'b1, x, 0, GREY, 24'h747474);
    end
    for (int x = 4; x < 8; x++) step(1'b0, 1'b0, 1'b1, x, 1, 24'h0A6464, 24'h3B6464);
    close_frame(1'b0);
    check("thresh_counts", last_cnt, 24'h000100);

    // Hysteresis on zone 3.
    reset_and_open();
    for (int f = 0; f < 6; f++) begin
      if (f < 3) begin
        for (int i = 0; i < 5; i++) pix(12 + (i % 4), i / 4, 1'b1);
      end
      close_frame(1'b0);
      check("hyst_flag3", last_flag[3], exp3[f]);
      check("hyst_any", last_any, exp3[f]);
    end

    // Collision: pixel before the pulse counts, pixel with the pulse is dropped.
    reset_and_open();
    pix(0, 0, 1'b1);
    close_frame(1'b1);
    check("collide_close", last_cnt, 24'h000001);
    close_frame(1'b0);
    check("collide_next", last_cnt, 24'h000000);

    // Mid-frame reset discards the in-flight frame.
    reset_and_open();
    for (int i = 0; i < 10; i++) pix(i, 0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 0, 0, GREY, GREY);
    n_mark = n_done;
    step(1'b0, 1'b1, 1'b0, 0, 0, GREY, GREY);
    idle(6);
    check("reset_no_done", n_done - n_mark, 0);
    pix(8, 2, 1'b1);
    pix(9, 3, 1'b1);
    close_frame(1'b0);
    check("reset_counts", last_cnt, 24'h002000);

    // Counter saturation.
    reset_and_open();
    for (int i = 0; i < 70; i++) pix(i % 4, (i / 4) % 4, 1'b1);
    close_frame(1'b0);
    check("saturate", last_cnt, 24'h00003F);

    // Back-to-back pulses in consecutive cycles.
    n_mark = n_done;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 0, 0, GREY, GREY);
    idle(5);
    check("b2b_dones", n_done - n_mark, 3);
    check("b2b_counts", last_cnt, 24'h000000);

`ifdef MOTION_BBOX_EN
    reset_and_open();
    pix(2, 1, 1'b1);
    pix(13, 3, 1'b1);
    pix(5, 2, 1'b0);
    close_frame(1'b0);
    check("bbox_hit", last_bbox, {1'b1, 10'd2, 10'd13, 10'd1, 10'd3});
    close_frame(1'b0);
    check("bbox_empty", last_bbox, 41'd0);
`endif

    // Randomised traffic against the model.
    reset_and_open();
    for (int i = 0; i < 900; i++) begin
      p = 24'($urandom);
      c = p;
      case ($urandom_range(0, 2))
        0: c = p;
        1: c = 24'($urandom);
        default: c[23:16] = p[23:16] + 8'($urandom_range(0, 60));
      endcase
      step($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
           int'($urandom_range(0, 19)), int'($urandom_range(0, 5)), c, p);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motion_zone_detector.md
Name: motion_zone_detector

Overview:
- Per-pixel frame-difference motion detector, next generation of the single-flag detector in the pong camera path.
- Splits the frame into ZONES vertical strips and counts changed pixels per strip.
- Applies frame-level hysteresis and raises a per-zone motion flag, so paddle logic can tell left-side from right-side player movement.
- Uses a 3-stage pipeline and contains no dividers.

Parameters:
- WIDTH, 640, active pixels per line.
- HEIGHT, 480, active lines per frame.
- PIX_W, 8, bits per colour channel.
- ZONES, 4, number of equal-width vertical strips. WIDTH % ZONES == 0 is required.
- PIX_THRESH, 48, a pixel is "changed" when |dR|+|dG|+|dB| > PIX_THRESH.
- COUNT_THRESH, 256, a zone is "raw active" in a frame when its changed count >= COUNT_THRESH.
- HOLD_FRAMES, 2, number of consecutive frames with a raw state differing from the flag before the flag toggles. Range 1..15.
- CNT_W, 20, width of each zone counter. Counters saturate.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- frame_start, in, 1, one-cycle pulse that closes the current frame and opens the next. It carries no pixel.
- pixel_valid, in, 1, qualifies the pixel inputs.
- pixel_x, in, 10, pixel column.
- pixel_y, in, 10, pixel row.
- cur_rgb, in, 3*PIX_W, current frame pixel as {R,G,B}.
- prev_rgb, in, 3*PIX_W, previous frame pixel at the same position, as {R,G,B}.
- frame_done, out, 1, one-cycle pulse; all outputs below are updated in this cycle.
- motion_zone, out, ZONES, hysteresis-filtered per-zone flag. Bit 0 is the leftmost strip.
- motion_any, out, 1, OR of motion_zone.
- zone_count, out, ZONES*CNT_W, changed-pixel counts of the last closed frame. Zone 0 is in the LSBs.

Behaviour:
- Clocking and reset:
  - One clock domain, clk.
  - rst is synchronous and active-high and overrides everything, including an in-flight frame.
  - Reset values: frame_done=0, motion_zone=0, motion_any=0, zone_count=0. All pipeline registers, accumulators and streak counters are cleared.
- Pixel acceptance:
  - A pixel is counted only when pixel_valid=1, pixel_x<WIDTH and pixel_y<HEIGHT. Other pixels are dropped.
  - If pixel_valid and frame_start are high in the same cycle, frame_start wins and the pixel is dropped.
- Pipeline:
  - S1 registers the three absolute channel differences, each PIX_W bits and unsigned.
  - S1 registers the zone index, computed from pixel_x by a comparator chain against k*(WIDTH/ZONES).
  - S2 registers the sum, PIX_W+2 bits and never overflowing, plus the changed bit (sum > PIX_THRESH).
  - S3 increments the selected zone accumulator, saturating at 2^CNT_W-1.
  - frame_start travels down the pipeline as a tag, so every pixel accepted before it is counted in the closing frame.
- Frame close:
  - Timing: frame_start high in cycle N gives frame_done=1 in cycle N+3.
  - In that same cycle zone_count takes the accumulator values and the flags update.
  - Accumulators restart at 0 in the same cycle. A changed pixel arriving in S3 in that cycle counts toward the new frame, starting at 1.
- Opening frame: the first frame_start after reset only opens a frame. It produces no frame_done and no output update.
- Hysteresis, per zone:
  - raw = count >= COUNT_THRESH.
  - If raw != motion_zone[z], streak[z] increments. If raw == motion_zone[z], streak[z] clears.
  - When streak reaches HOLD_FRAMES, the flag toggles and streak clears.
  - With HOLD_FRAMES=1 the flag follows raw every frame.
- motion_any is registered and updates in the frame_done cycle.
- Back-to-back frame_start pulses, including pulses in consecutive cycles, are legal. An empty frame closes with all counts 0.

Optional Feature:
MOTION_BBOX_EN:
- Defined: adds four outputs, each 10 bits: bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax. These give the bounding box of all changed pixels in the last closed frame and update in the frame_done cycle. Also adds bbox_valid, 1 bit, set when the frame had at least one changed pixel.
  - If no pixel changed, bbox_valid=0 and the four coordinates hold 0.
  - Internal min trackers reset to 10'h3FF and max trackers to 0 at each frame close.
  - All bbox outputs reset to 0.
- Not defined: none of these ports or registers exist.

Test Plan:
All scenarios use WIDTH=16, HEIGHT=4, ZONES=4, PIX_THRESH=48, COUNT_THRESH=3, HOLD_FRAMES=2.
1. Reset, then frame_start, then 64 pixels with cur_rgb==prev_rgb, then frame_start -> frame_done exactly 3 cycles after the second pulse; zone_count all 0; motion_zone=0.
2. Threshold edge: 4 pixels in zone 1 (x=4..7) with dR=16, dG=16, dB=16 (sum 48), plus 4 pixels with dR=49 and dG=dB=0 -> zone_count[1]=4 and all other zones 0.
3. Hysteresis: zone 3 gets 5 changed pixels per frame for 3 frames, then 0 for 3 frames -> motion_zone[3] rises at the 2nd frame_done, falls at the 5th, and motion_any tracks it.
4. Collision and pipeline flush: changed pixel at x=0 in cycle N-1, frame_start together with a changed pixel in cycle N -> the first pixel is counted in the closing frame and the second is dropped.
5. Reset in mid-frame after 10 changed pixels, then frame_start -> no frame_done. The next frame closes with counts of new pixels only.
6. With MOTION_BBOX_EN defined, changed pixels at (2,1) and (13,3) -> bbox=(2,13,1,3) and bbox_valid=1. A following frame with no changed pixels -> bbox_valid=0.
